jt900h_busarb: RTL

//  Arbiter/sequencer sharing the single 16-bit RAM port between three requesters:

---
 rtl/jt900h_busarb_if.sv | 46 ++++
 rtl/jt900h_busarb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jt900h_busarb_if.sv
// Bus bundle between the requesters (store / indexed load / opcode fetch),
// the arbiter and the external 16-bit RAM port.
//   wr_*     : store request, byte address, one-hot size, data, completion pulse
//   rd_*     : data read request, byte address, one-hot size, completion pulse
//   op_*     : opcode fetch request (always 16 bits), byte address, completion pulse
//   dout     : little-endian read/fetch result, busy: transfer in progress
//   ram_*    : RAM pins (word-aligned byte address, read data, write data, byte enables)
// Modports: slave = arbiter side, master = requester/RAM side.
interface jt900h_busarb_if;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [2:0]  wr_len;
    logic [31:0] wr_data;
    logic        wr_rdy;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [2:0]  rd_len;
    logic        rd_rdy;
    logic        op_req;
    logic [23:0] op_addr;
    logic        op_rdy;
    logic [31:0] dout;
    logic        busy;
    logic [23:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] ram_din;
    logic [1:0]  ram_we;

    modport slave (
        input  wr_req, wr_addr, wr_len, wr_data,
        input  rd_req, rd_addr, rd_len,
        input  op_req, op_addr,
        input  ram_dout,
        output wr_rdy, rd_rdy, op_rdy, dout, busy,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output wr_req, wr_addr, wr_len, wr_data,
        output rd_req, rd_addr, rd_len,
        output op_req, op_addr,
        output ram_dout,
        input  wr_rdy, rd_rdy, op_rdy, dout, busy,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/jt900h_busarb.sv
// Shares one 16-bit RAM port between store, data read and opcode fetch.
// Each granted transfer (8/16/32 bits, any alignment) is split into aligned
// 16-bit beats; read bytes are packed little-endian into dout.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active high
//   cen  : clock enable, all state advances only when high
//   bus  : request/response and RAM signals (see jt900h_busarb_if)
// Parameters:
//   RAM_LAT : cen cycles the address is held on a read beat before sampling (1..3)
//   STARVE  : cen cycles a waiting fetch tolerates before it outranks read/write
module jt900h_busarb #(
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned STARVE  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    jt900h_busarb_if.slave  bus
);
    localparam int unsigned CntW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {StIdle, StBeat, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic [2:0]     kind_q, kind_d;        // one-hot: [0] store, [1] read, [2] fetch
    logic [23:0]    ram_addr_q, ram_addr_d;
    logic           lo_q, lo_d;            // start address is odd
    logic [2:0]     bytes_q, bytes_d;
    logic [1:0]     nbeat_q, nbeat_d;
    logic [1:0]     beat_q, beat_d;
    logic [1:0]     lat_q, lat_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    dout_q, dout_d;
    logic [CntW-1:0] starve_q, starve_d;

    // Grant decode
    logic           op_urgent, g_wr, g_rd, g_op;
    logic [23:0]    g_addr;
    logic [2:0]     g_len, g_bytes;

    // Per-lane view of the current beat: lane 0 = even byte, lane 1 = odd byte
    logic [3:0]     lane_off [2];
    logic [1:0]     lane_en;
    logic [15:0]    lane_din;
    logic [31:0]    acc_merged;
    logic           last_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            kind_q     <= '0;
            ram_addr_q <= '0;
            lo_q       <= 1'b0;
            bytes_q    <= '0;
            nbeat_q    <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            acc_q      <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            ram_addr_q <= ram_addr_d;
            lo_q       <= lo_d;
            bytes_q    <= bytes_d;
            nbeat_q    <= nbeat_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            acc_q      <= acc_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        op_urgent = bus.op_req && (starve_q >= CntW'(STARVE));
        g_wr      = bus.wr_req && !op_urgent;
        g_rd      = bus.rd_req && !bus.wr_req && !op_urgent;
        g_op      = bus.op_req && (op_urgent || (!bus.wr_req && !bus.rd_req));
        g_addr    = g_wr ? bus.wr_addr : (g_rd ? bus.rd_addr : bus.op_addr);
        g_len     = g_wr ? bus.wr_len  : (g_rd ? bus.rd_len  : 3'b010);
        case (g_len)
            3'b010:  g_bytes = 3'd2;
            3'b100:  g_bytes = 3'd4;
            default: g_bytes = 3'd1;
        endcase
    end

    // Byte offset within the transfer carried by each lane; negative offsets
    // wrap to large values and so fall outside the enable window.
    always_comb begin
        acc_merged = acc_q;
        for (int b = 0; b < 2; b++) begin
            lane_off[b] = {1'b0, beat_q, 1'b0} + 4'(b) - {3'b000, lo_q};
            lane_en[b]  = lane_off[b] < {1'b0, bytes_q};
            lane_din[b*8 +: 8] = wdata_q[{lane_off[b][1:0], 3'b000} +: 8];
            if (lane_en[b]) begin
                acc_merged[{lane_off[b][1:0], 3'b000} +: 8] = bus.ram_dout[b*8 +: 8];
            end
        end
        last_lat = kind_q[0] || (lat_q == 2'(RAM_LAT - 1));
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        ram_addr_d = ram_addr_q;
        lo_d       = lo_q;
        bytes_d    = bytes_q;
        nbeat_d    = nbeat_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        acc_d      = acc_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        starve_d   = starve_q;
        if (cen) begin
            if (state_q == StIdle && g_op) begin
                starve_d = '0;
            end else if (bus.op_req && starve_q < CntW'(STARVE)) begin
                starve_d = starve_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (g_wr || g_rd || g_op) begin
                        kind_d     = {g_op, g_rd, g_wr};
                        ram_addr_d = {g_addr[23:1], 1'b0};
                        lo_d       = g_addr[0];
                        bytes_d    = g_bytes;
                        nbeat_d    = 2'(({2'b00, g_addr[0]} + g_bytes + 3'd1) >> 1);
                        beat_d     = '0;
                        lat_d      = '0;
                        acc_d      = '0;
                        wdata_d    = bus.wr_data;
                        state_d    = StBeat;
                    end
                end
                StBeat, StWait: begin
                    if (!last_lat) begin
                        lat_d   = lat_q + 2'd1;
                        state_d = StWait;
                    end else begin
                        if (!kind_q[0]) acc_d = acc_merged;
                        if (beat_q == nbeat_q - 2'd1) begin
                            if (!kind_q[0]) dout_d = acc_merged;
                            state_d = StDone;
                        end else begin
                            beat_d     = beat_q + 2'd1;
                            lat_d      = '0;
                            ram_addr_d = ram_addr_q + 24'd2;  // wraps at 24 bits
                            state_d    = StBeat;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decode registered state only, so cen=0 holds them.
    always_comb begin
        bus.ram_addr = ram_addr_q;
        bus.ram_we   = '0;
        bus.ram_din  = '0;
        if (state_q == StBeat && kind_q[0]) begin
            bus.ram_we  = lane_en;
            bus.ram_din = lane_din;
        end
        bus.busy   = (state_q == StBeat) || (state_q == StWait);
        bus.wr_rdy = (state_q == StDone) && kind_q[0];
        bus.rd_rdy = (state_q == StDone) && kind_q[1];
        bus.op_rdy = (state_q == StDone) && kind_q[2];
        bus.dout   = dout_q;
    end
endmodule
